// File: rtl/addsub_result_accumulator.sv
// rtl/addsub_result_accumulator.sv - frames adder/subtractor results into signed totals with sticky overflow
module addsub_result_accumulator #(
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [3:0]                     din,
    input  logic                           carry_barrow,
    input  logic                           sel,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_W-1:0]               acc_out,
    output logic                           ovf,
    output logic [$clog2(N_SAMPLES+1)-1:0] count
);

    localparam int CW = $clog2(N_SAMPLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [ACC_W-1:0]  acc, acc_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic              ovf_q, ovf_next;

    logic              accept;
    logic [ACC_W-1:0]  value;
    logic [ACC_W-1:0]  sum;
    logic              add_ovf;
    logic [CW-1:0]     cnt_inc;

    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign acc_out   = acc;
    assign ovf       = ovf_q;
    assign count     = cnt;

    // sel=1 results carry a borrow, so the 5-bit word is signed; add results are unsigned
    assign value   = sel ? {{(ACC_W-5){carry_barrow}}, carry_barrow, din}
                         : {{(ACC_W-5){1'b0}}, carry_barrow, din};
    assign sum     = acc + value;
    assign add_ovf = (acc[ACC_W-1] == value[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    assign cnt_inc = cnt + CW'(1);

    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        ovf_next   = ovf_q;
        case (state)
            IDLE, ACCUM: begin
                // acc, cnt and ovf are already zero in IDLE, so the first sample uses the same add path
                if (accept) begin
                    acc_next = sum;
                    cnt_next = cnt_inc;
                    ovf_next = ovf_q | add_ovf;
                    if (cnt_inc == CW'(N_SAMPLES)) begin
                        state_next = DONE;
                    end else begin
                        state_next = ACCUM;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                    acc_next   = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                acc_next   = '0;
                cnt_next   = '0;
                ovf_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            ovf_q <= ovf_next;
        end
    end

endmodule

// File: tb/tb_addsub_result_accumulator.sv
// tb/tb_addsub_result_accumulator.sv - directed self-checking bench for addsub_result_accumulator
module tb_addsub_result_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       clr, in_valid, in_ready, cb, sel, out_valid, out_ready, ovf;
    logic [3:0] din;
    logic [7:0] acc_out;
    logic [2:0] count;

    logic       b_clr, b_in_valid, b_in_ready, b_cb, b_sel, b_out_valid, b_out_ready, b_ovf;
    logic [3:0] b_din;
    logic [5:0] b_acc_out;
    logic [2:0] b_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    addsub_result_accumulator u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .carry_barrow(cb), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .ovf(ovf), .count(count)
    );

    addsub_result_accumulator #(.N_SAMPLES(4), .ACC_W(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .clr(b_clr),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .din(b_din), .carry_barrow(b_cb), .sel(b_sel),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .acc_out(b_acc_out), .ovf(b_ovf), .count(b_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [3:0] d, input logic c, input logic s);
        in_valid = 1'b1;
        din      = d;
        cb       = c;
        sel      = s;
        step();
    endtask

    task automatic put_b(input logic [3:0] d, input logic c, input logic s);
        b_in_valid = 1'b1;
        b_din      = d;
        b_cb       = c;
        b_sel      = s;
        step();
    endtask

    task automatic sub_frame(input string tag);
        put(4'b1010, 1'b1, 1'b1);
        put(4'b1111, 1'b1, 1'b1);
        put(4'b0011, 1'b0, 1'b1);
        put(4'b0000, 1'b1, 1'b1);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_acc"},   acc_out, 8'hEC);
        chk({tag, "_ovf"},   ovf, 0);
        chk({tag, "_count"}, count, 4);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        din = 4'bx; cb = 1'bx; sel = 1'bx;
        b_clr = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        b_din = 4'b0; b_cb = 1'b0; b_sel = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_in_ready",  in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_acc",       acc_out, 0);
        chk("rst_count",     count, 0);
        chk("rst_ovf",       ovf, 0);

        // add frame: 30 + 5 + 17 + 15 = 67
        put(4'b1110, 1'b1, 1'b0);
        chk("add1_acc", acc_out, 8'h1E);
        chk("add1_count", count, 1);
        put(4'b0101, 1'b0, 1'b0);
        put(4'b0001, 1'b1, 1'b0);
        chk("add3_count", count, 3);
        chk("add3_valid", out_valid, 0);
        put(4'b1111, 1'b0, 1'b0);
        chk("add_valid",    out_valid, 1);
        chk("add_in_ready", in_ready, 0);
        chk("add_acc",      acc_out, 8'h43);
        chk("add_ovf",      ovf, 0);
        chk("add_count",    count, 4);

        // backpressure with in_valid asserted
        for (int i = 0; i < 3; i++) begin
            put(4'b0111, 1'b0, 1'b0);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid",    out_valid, 1);
            chk("bp_acc",      acc_out, 8'h43);
            chk("bp_count",    count, 4);
        end
        out_ready = 1'b1;
        put(4'b0111, 1'b0, 1'b0);
        chk("hs_valid",    out_valid, 0);
        chk("hs_in_ready", in_ready, 1);
        chk("hs_count",    count, 0);
        chk("hs_acc",      acc_out, 0);
        out_ready = 1'b0;

        // sub frame with an idle gap: -6 -1 +3 -16 = -20
        put(4'b1010, 1'b1, 1'b1);
        chk("sub1_count", count, 1);
        chk("sub1_acc",   acc_out, 8'hFA);
        in_valid = 1'b0;
        din = 4'bx; cb = 1'bx; sel = 1'bx;
        step();
        chk("gap_count", count, 1);
        chk("gap_acc",   acc_out, 8'hFA);
        put(4'b1111, 1'b1, 1'b1);
        put(4'b0011, 1'b0, 1'b1);
        put(4'b0000, 1'b1, 1'b1);
        chk("sub_valid", out_valid, 1);
        chk("sub_acc",   acc_out, 8'hEC);
        chk("sub_ovf",   ovf, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("sub_hs_valid", out_valid, 0);

        // abort mid-frame, clr wins over an offered sample
        put(4'b1111, 1'b1, 1'b0);
        put(4'b1111, 1'b1, 1'b0);
        chk("ab2_acc",   acc_out, 8'h3E);
        chk("ab2_count", count, 2);
        clr = 1'b1;
        put(4'b1111, 1'b1, 1'b0);
        clr = 1'b0;
        chk("clr_acc",      acc_out, 0);
        chk("clr_count",    count, 0);
        chk("clr_valid",    out_valid, 0);
        chk("clr_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) put(4'b0001, 1'b0, 1'b0);
        chk("ones_valid", out_valid, 1);
        chk("ones_acc",   acc_out, 8'h04);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // overflow in a 6-bit accumulator: 31 + 31 wraps to -2
        put_b(4'b1111, 1'b1, 1'b0);
        chk("ov1_acc", b_acc_out, 6'h1F);
        chk("ov1_ovf", b_ovf, 0);
        put_b(4'b1111, 1'b1, 1'b0);
        chk("ov2_acc", b_acc_out, 6'h3E);
        chk("ov2_ovf", b_ovf, 1);
        put_b(4'b0000, 1'b0, 1'b0);
        chk("ov3_ovf", b_ovf, 1);
        put_b(4'b0000, 1'b0, 1'b0);
        chk("ov4_valid", b_out_valid, 1);
        chk("ov4_acc",   b_acc_out, 6'h3E);
        chk("ov4_ovf",   b_ovf, 1);
        b_in_valid = 1'b0;
        step();
        chk("ov_hold_ovf", b_ovf, 1);
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
        chk("ov_hs_ovf",   b_ovf, 0);
        chk("ov_hs_valid", b_out_valid, 0);
        put_b(4'b0001, 1'b0, 1'b0);
        b_in_valid = 1'b0;
        chk("ov_next_ovf", b_ovf, 0);
        chk("ov_next_acc", b_acc_out, 6'h01);

        // reset mid-frame after 3 accepts
        put(4'b1010, 1'b1, 1'b1);
        put(4'b1111, 1'b1, 1'b1);
        put(4'b0011, 1'b0, 1'b1);
        chk("pre_rst_count", count, 3);
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mrst_acc",      acc_out, 0);
        chk("mrst_count",    count, 0);
        chk("mrst_ovf",      ovf, 0);
        chk("mrst_valid",    out_valid, 0);
        chk("mrst_in_ready", in_ready, 1);
        sub_frame("post_rst");
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
